// File: rtl/serv_mem_if_pkg.sv
// serv_mem_if_pkg: shared state encodings, access-width codes and lane helpers
// for the bit-serial memory interface.
package serv_mem_if_pkg;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_REQ, S_WAIT_ACK, S_RUN} state_t;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    function automatic logic [3:0] lane_sel(input logic [1:0] w, input logic [1:0] a);
        return (w == W_BYTE) ? (4'b0001 << a) : (w == W_HALF) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [1:0] w, input logic [1:0] a);
        return (w == W_HALF && a[0]) || (w == W_WORD && a != 2'b00);
    endfunction

    // Index of the most significant valid bit of the loaded value.
    function automatic logic [4:0] last_bit(input logic [1:0] w);
        return (w == W_BYTE) ? 5'd7 : (w == W_HALF) ? 5'd15 : 5'd31;
    endfunction

endpackage

// File: rtl/serv_ser_add.sv
// serv_ser_add: 1-bit serial adder, LSB first, with a carry flop that is
// ignored on the first bit when i_clr is high.
module serv_ser_add (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_a,
    input  logic i_b,
    output logic o_q
);
    logic carry_q, carry_d, cin;

    always_comb begin
        cin     = carry_q && !i_clr;
        o_q     = i_a ^ i_b ^ cin;
        carry_d = i_en ? ((i_a && i_b) || (i_a && cin) || (i_b && cin)) : carry_q;
    end

    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) carry_q <= 1'b0;
        else          carry_q <= carry_d;

endmodule

// File: rtl/serv_mem_if.sv
// serv_mem_if: bit-serial load/store unit; builds address and store data
// serially, issues one bus request, then streams the load result out serially.
module serv_mem_if
    import serv_mem_if_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_init,
    input  logic        i_cmd,
    input  logic [2:0]  i_funct3,
    input  logic        i_rs1,
    input  logic        i_imm,
    input  logic        i_rs2,
    output logic        o_busy,
    output logic        o_rd,
    output logic        o_misalign,
    output logic [31:0] o_d_addr,
    output logic [31:0] o_d_dat,
    output logic [3:0]  o_d_sel,
    output logic        o_d_we,
    output logic        o_d_vld,
    input  logic        i_d_rdy,
    input  logic [31:0] i_d_rdt,
    input  logic        i_d_ack
);
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, idx;
    logic [31:0] addr_q, addr_d, dat_q, dat_d, rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d, busy_q, busy_d, mis_q, mis_d;
    logic        sum, entry, init_bit, run_bit, init_done, ack_now, mis_now, in_w;

    serv_ser_add u_add (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_en    (init_bit),
        .i_clr   (cnt_q == 5'd0),
        .i_a     (i_rs1),
        .i_b     (i_imm),
        .o_q     (sum)
    );

    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (entry) state_d = S_INIT;
            S_INIT:     if (init_done) state_d = mis_now ? S_RUN : S_REQ;
            S_REQ:      if (i_d_rdy) state_d = i_d_ack ? S_RUN : S_WAIT_ACK;
            S_WAIT_ACK: if (i_d_ack) state_d = S_RUN;
            S_RUN:      if (run_bit && cnt_q == 5'd31) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entry     = state_q == S_IDLE && i_en && i_init;
        init_bit  = state_q == S_INIT && i_en;
        run_bit   = state_q == S_RUN && i_en;
        init_done = init_bit && cnt_q == 5'd31;
        ack_now   = i_d_ack && (state_q == S_WAIT_ACK || (state_q == S_REQ && i_d_rdy));
        cnt_d     = (init_bit || run_bit) ? cnt_q + 5'd1 : cnt_q;
        addr_d    = init_bit ? {sum, addr_q[31:1]} : addr_q;
        dat_d     = init_bit ? {i_rs2, dat_q[31:1]} : dat_q;
        mis_now   = misaligned(f3_q[1:0], addr_d[1:0]);
        f3_d      = entry ? i_funct3 : f3_q;
        we_d      = entry ? i_cmd : we_q;
        mis_d     = entry ? 1'b0 : init_done ? mis_now : mis_q;
        sel_d     = init_done ? lane_sel(f3_q[1:0], addr_d[1:0]) : sel_q;
        busy_d    = init_done ? !mis_now : ack_now ? 1'b0 : busy_q;
        rdata_d   = (ack_now && !we_q) ? i_d_rdt : rdata_q;
    end

    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            mis_q   <= mis_d;
        end

    // Past the access width the index sticks on the top bit, giving sign extension.
    always_comb begin
        o_d_vld    = state_q == S_REQ;
        in_w       = cnt_q <= last_bit(f3_q[1:0]);
        idx        = (in_w ? cnt_q : last_bit(f3_q[1:0])) + {addr_q[1:0], 3'b000};
        o_rd       = state_q == S_RUN && !we_q && !mis_q && (in_w || !f3_q[2]) && rdata_q[idx];
        o_d_dat    = (f3_q[1:0] == W_BYTE) ? {4{dat_q[7:0]}} : (f3_q[1:0] == W_HALF) ? {2{dat_q[15:0]}} : dat_q;
        o_d_addr   = addr_q;
        o_d_sel    = sel_q;
        o_d_we     = we_q;
        o_busy     = busy_q;
        o_misalign = mis_q;
    end

endmodule

// File: tb/tb_serv_mem_if.sv
// tb_serv_mem_if: drives serial load/store transactions and checks the DUT
// every cycle against a word-level model of address, lanes and load result.
module tb_serv_mem_if;
    logic        clk = 1'b0, i_rst_n = 1'b0;
    logic        i_en = 0, i_init = 0, i_cmd = 0, i_rs1 = 0, i_imm = 0, i_rs2 = 0;
    logic [2:0]  i_funct3 = 0;
    logic        o_busy, o_rd, o_misalign, o_d_we, o_d_vld;
    logic [31:0] o_d_addr, o_d_dat;
    logic [3:0]  o_d_sel;
    logic        i_d_rdy = 0, i_d_ack = 0;
    logic [31:0] i_d_rdt = 0;

    int n_cmp = 0, n_mis = 0;
    bit chk_on = 0;
    logic        exp_vld = 0, exp_busy = 0, exp_mis = 0, exp_we = 0, exp_rd_on = 0, exp_rd = 0;
    logic [31:0] exp_addr = 0, exp_dat = 0;
    logic [3:0]  exp_sel = 0;

    serv_mem_if dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_init(i_init), .i_cmd(i_cmd),
        .i_funct3(i_funct3), .i_rs1(i_rs1), .i_imm(i_imm), .i_rs2(i_rs2),
        .o_busy(o_busy), .o_rd(o_rd), .o_misalign(o_misalign), .o_d_addr(o_d_addr),
        .o_d_dat(o_d_dat), .o_d_sel(o_d_sel), .o_d_we(o_d_we), .o_d_vld(o_d_vld),
        .i_d_rdy(i_d_rdy), .i_d_rdt(i_d_rdt), .i_d_ack(i_d_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_mis(input logic [31:0] a, input logic [2:0] f3);
        return (f3[1:0] == 2'd1 && a % 2 != 0) || (f3[1:0] == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [2:0] f3);
        int nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        int base = (nb == 4) ? 0 : (a % 4);
        return 4'((2 ** nb - 1) << base);
    endfunction

    function automatic logic [31:0] m_dat(input logic [31:0] d, input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_res(input logic [31:0] a, input logic [2:0] f3, input logic cmd, input logic [31:0] rdt);
        int bits = (f3[1:0] == 2'd0) ? 8 : (f3[1:0] == 2'd1) ? 16 : 32;
        logic [31:0] v, m;
        if (cmd || m_mis(a, f3)) return 32'h0;
        if (bits == 32) return rdt;
        v = rdt >> (8 * (a % 4));
        m = (32'h1 << bits) - 1;
        v = v & m;
        if (!f3[2] && v >= (m + 1) / 2) v = v | ~m;
        return v;
    endfunction

    always @(negedge clk) if (chk_on) begin
        chk("vld", o_d_vld, exp_vld);
        chk("busy", o_busy, exp_busy);
        chk("misalign", o_misalign, exp_mis);
        if (exp_vld) begin
            chk("addr", o_d_addr, exp_addr);
            chk("sel", o_d_sel, exp_sel);
            chk("dat", o_d_dat, exp_dat);
            chk("we", o_d_we, exp_we);
        end
        if (exp_rd_on) chk("rd", o_rd, exp_rd);
    end

    // ack_dly < 0 means ack in the same cycle as rdy; abort pulls reset during WAIT_ACK.
    task automatic txn(input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                       input logic [2:0] f3, input logic cmd, input logic [31:0] rdt,
                       input int rdy_dly, input int ack_dly, input bit abort, input bit pin,
                       input logic [31:0] p_addr, input logic [3:0] p_sel,
                       input logic [31:0] p_dat, input logic [31:0] p_rd);
        logic [31:0] a = rs1 + imm;
        logic [31:0] res = m_res(a, f3, cmd, rdt);
        logic [31:0] got = 0;
        bit mis = m_mis(a, f3);
        i_en = 1; i_init = 1; i_cmd = cmd; i_funct3 = f3;
        tick();
        exp_mis = 0;
        for (int i = 0; i < 32;) begin
            i_init = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                i_en = 0; i_rs1 = 1'($urandom); i_imm = 1'($urandom); i_rs2 = 1'($urandom);
            end else begin
                i_en = 1; i_rs1 = rs1[i]; i_imm = imm[i]; i_rs2 = rs2[i]; i++;
            end
            tick();
        end
        i_en = 0; i_init = 0;
        exp_busy = !mis; exp_mis = mis;
        if (!mis) begin
            exp_vld = 1; exp_addr = a; exp_sel = m_sel(a, f3); exp_dat = m_dat(rs2, f3); exp_we = cmd;
            if (pin) begin
                chk("pin_addr", o_d_addr, p_addr);
                chk("pin_sel", o_d_sel, 32'(p_sel));
                chk("pin_dat", o_d_dat, p_dat);
            end
            for (int k = 0; k < rdy_dly; k++) begin
                i_en = 1'($urandom); i_init = 1'($urandom); i_d_rdt = $urandom;
                tick();
            end
            i_en = 0; i_init = 0; i_d_rdy = 1;
            if (ack_dly < 0) begin
                i_d_ack = 1; i_d_rdt = rdt;
                tick();
                i_d_rdy = 0; i_d_ack = 0; exp_vld = 0; exp_busy = 0;
            end else begin
                tick();
                i_d_rdy = 0; exp_vld = 0;
                for (int k = 0; k < ack_dly; k++) begin
                    i_en = 1'($urandom); i_init = 1'($urandom); i_d_rdt = $urandom;
                    tick();
                end
                i_en = 0; i_init = 0;
                if (abort) begin
                    i_rst_n = 0; exp_busy = 0; exp_mis = 0;
                    #1;
                    chk("rst_vld", o_d_vld, 0);
                    chk("rst_busy", o_busy, 0);
                    chk("rst_addr", o_d_addr, 0);
                    chk("rst_sel", 32'(o_d_sel), 0);
                    tick(); tick();
                    i_rst_n = 1; i_d_ack = 1; i_d_rdt = rdt;
                    tick();
                    i_d_ack = 0;
                    return;
                end
                i_d_ack = 1; i_d_rdt = rdt;
                tick();
                i_d_ack = 0; exp_busy = 0;
            end
        end
        for (int i = 0; i < 32;) begin
            if ($urandom_range(0, 3) == 0) begin
                i_en = 0; exp_rd_on = 0;
                tick();
            end else begin
                i_en = 1; exp_rd_on = 1; exp_rd = res[i];
                @(negedge clk);
                got[i] = o_rd;
                i++;
                tick();
            end
        end
        i_en = 0; exp_rd_on = 0;
        if (pin) chk("pin_rd", got, p_rd);
    endtask

    initial begin
        logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        tick(); tick();
        chk("reset_vld", o_d_vld, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_mis", o_misalign, 0);
        chk("reset_rd", o_rd, 0);
        chk("reset_we", o_d_we, 0);
        chk("reset_addr", o_d_addr, 0);
        chk("reset_dat", o_d_dat, 0);
        chk("reset_sel", 32'(o_d_sel), 0);
        i_rst_n = 1;
        tick();
        chk_on = 1;
        txn(32'h1000, 32'h4, 0, 3'b010, 0, 32'hDEADBEEF, 1, 1, 0, 1, 32'h1004, 4'b1111, 0, 32'hDEADBEEF);
        txn(32'h2000, 32'h3, 0, 3'b000, 0, 32'h80000000, 0, 2, 0, 1, 32'h2003, 4'b1000, 0, 32'hFFFFFF80);
        txn(32'h2000, 32'h3, 0, 3'b100, 0, 32'h80000000, 2, 0, 0, 1, 32'h2003, 4'b1000, 0, 32'h00000080);
        txn(32'h8, 32'h8, 32'h1234ABCD, 3'b001, 1, 32'h5555AAAA, 5, 2, 0, 1, 32'h10, 4'b0011, 32'hABCDABCD, 0);
        txn(32'h3000, 32'h1, 0, 3'b001, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0);
        txn(32'h100, 32'h20, 0, 3'b010, 0, 32'h0F0F1234, 5, -1, 0, 1, 32'h120, 4'b1111, 0, 32'h0F0F1234);
        txn(32'h40, 32'h0, 0, 3'b010, 0, 32'h11111111, 1, 3, 1, 0, 0, 0, 0, 0);
        txn(32'h1000, 32'h4, 0, 3'b010, 0, 32'hCAFEF00D, 0, 1, 0, 1, 32'h1004, 4'b1111, 0, 32'hCAFEF00D);
        for (int t = 0; t < 40; t++) begin
            logic cmd = 1'($urandom);
            logic [2:0] f3 = cmd ? 3'($urandom_range(0, 2)) : f3s[$urandom_range(0, 4)];
            logic [31:0] rs1 = $urandom;
            if ($urandom_range(0, 1) == 0) rs1[1:0] = 2'b00;
            txn(rs1, 32'($urandom_range(0, 64)), $urandom, f3, cmd, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 4) - 1, 0, 0, 0, 0, 0, 0);
        end
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
